// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage bus engine. Takes a decoded load/store (direction, store size,
// load funct3, byte address, LSB-aligned store data), checks alignment, builds
// byte enables and lane-replicated write data, runs one req/ack transaction on
// the data-memory port, and returns sign/zero-extended load data. The pipeline
// is stalled for as long as a transaction is in flight.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   valid_in          memory op present (sampled only while idle)
//   rw                0 = read, 1 = write
//   store_sel         00 = W, 01 = H, 10 = B, 11 = W
//   load_funct3       LB/LH/LW/LBU/LHU; unknown encodings behave as LW
//   addr, wdata       byte address and LSB-aligned store data
//   mem_req/we/addr/be/wdata   data-memory request (held stable until ack)
//   mem_ack, mem_rdata         one-cycle completion and read word
//   stall             high whenever a transaction is in progress
//   done              one-cycle completion pulse
//   load_data         extended load result, held until the next load completes
//   misaligned        one-cycle pulse for a rejected misaligned access
//   bus_err           one-cycle pulse when the ack timeout expires
//
// TIMEOUT is the number of bus cycles allowed without an ack; 0 disables it.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        rw,
  input  logic [1:0]  store_sel,
  input  logic [2:0]  load_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // design still elaborates with the timeout disabled.
  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          misaligned_q, misaligned_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Byte offset and funct3 of the op in flight, needed to pick and extend
  // the returned lane.
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [2:0]    funct3_q, funct3_d;

  // ---------------------------------------------------------------------------
  // Request decode (from the live inputs, used only when accepting in IDLE)
  // ---------------------------------------------------------------------------
  size_e       size_in;
  logic        aligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    size_in    = SZ_W;
    aligned_in = 1'b1;
    be_in      = 4'b1111;
    wdata_in   = wdata;

    if (rw) begin
      unique case (store_sel)
        2'b01:   size_in = SZ_H;
        2'b10:   size_in = SZ_B;
        default: size_in = SZ_W;
      endcase
    end else begin
      unique case (load_funct3[1:0])
        2'b00:   size_in = SZ_B;
        2'b01:   size_in = SZ_H;
        default: size_in = SZ_W;
      endcase
    end

    unique case (size_in)
      SZ_B: begin
        aligned_in = 1'b1;
        be_in      = 4'b0001 << addr[1:0];
        wdata_in   = {4{wdata[7:0]}};
      end
      SZ_H: begin
        aligned_in = ~addr[0];
        be_in      = addr[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{wdata[15:0]}};
      end
      default: begin
        aligned_in = (addr[1:0] == 2'b00);
        be_in      = 4'b1111;
        wdata_in   = wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane selection and extension (from the latched op)
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  always_comb begin
    byte_lane = mem_rdata[7:0];
    half_lane = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext  = mem_rdata;

    unique case (addr_lo_q)
      2'd0: byte_lane = mem_rdata[7:0];
      2'd1: byte_lane = mem_rdata[15:8];
      2'd2: byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase

    // funct3[2] distinguishes the unsigned forms (LBU/LHU).
    unique case (funct3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'd0, byte_lane};
      3'b101:  load_ext = {16'd0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (!aligned_in) begin
            // Rejected outright: no bus traffic, stay idle.
            misaligned_d = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = rw;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_in;
            mem_wdata_d = wdata_in;
            addr_lo_d   = addr[1:0];
            funct3_d    = load_funct3;
            cnt_d       = '0;
            state_d     = S_BUS;
          end
        end
      end

      S_BUS: begin
        // An ack on the last allowed cycle is checked first, so it wins
        // over the timeout.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            load_data_d = load_ext;
          end
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == LAST)) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      funct3_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  // Both decoded straight from state so they vanish together with it on reset.
  assign stall      = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
